// File: rtl/superalu_share_sched_pkg.sv
// Shared constants and types for the super ALU share scheduler.
// Holds the op code map, FSM state encoding and default watchdog length.
package superalu_share_sched_pkg;

  localparam logic [2:0] SUPERALU_OP_MUL    = 3'b001;
  localparam logic [2:0] SUPERALU_OP_DIV    = 3'b010;
  localparam logic [2:0] SUPERALU_OP_SQRT   = 3'b011;
  localparam logic [2:0] SUPERALU_OP_CORDIC = 3'b100;

  localparam int unsigned SUPERALU_DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } sched_state_e;

endpackage

// File: rtl/superalu_share_sched_if.sv
// Requester-side and ALU-side signals of the share scheduler.
// slave is the scheduler's view; master is the requesters plus ALU.
interface superalu_share_sched_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OP_WIDTH   = 3
);
  logic [NUM_REQ-1:0]            REQ;
  logic [NUM_REQ*OP_WIDTH-1:0]   REQ_OP;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_A;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_B;
  logic [NUM_REQ-1:0]            GNT;
  logic [NUM_REQ-1:0]            ACK;
  logic [DATA_WIDTH-1:0]         RES_A;
  logic [DATA_WIDTH-1:0]         RES_B;
  logic                          ERR;
  logic                          BUSY;
  logic                          ALU_START;
  logic                          ALU_ABORT;
  logic [OP_WIDTH-1:0]           ALU_OP;
  logic [DATA_WIDTH-1:0]         ALU_A;
  logic [DATA_WIDTH-1:0]         ALU_B;
  logic                          ALU_DONE;
  logic [DATA_WIDTH-1:0]         ALU_FOUT;
  logic [DATA_WIDTH-1:0]         ALU_POUT;

  modport slave (
    input  REQ, REQ_OP, REQ_A, REQ_B, ALU_DONE, ALU_FOUT, ALU_POUT,
    output GNT, ACK, RES_A, RES_B, ERR, BUSY, ALU_START, ALU_ABORT, ALU_OP, ALU_A, ALU_B
  );

  modport master (
    output REQ, REQ_OP, REQ_A, REQ_B, ALU_DONE, ALU_FOUT, ALU_POUT,
    input  GNT, ACK, RES_A, RES_B, ERR, BUSY, ALU_START, ALU_ABORT, ALU_OP, ALU_A, ALU_B
  );

endinterface

// File: rtl/superalu_share_sched_rr_arbiter_onehot.sv
// Combinational round-robin arbiter: searches from ptr_i+1 with wraparound
// and returns a one-hot winner (all zero when nothing requests).
module superalu_share_sched_rr_arbiter_onehot #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned PtrW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic            found;
  logic [PtrW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PtrW'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/superalu_share_sched.sv
// Shares one iterative super ALU between NUM_REQ requesters: round-robin grant,
// start/done sequencing, watchdog abort, and result return to the granted requester.
module superalu_share_sched
  import superalu_share_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OP_WIDTH   = 3,
  parameter int unsigned TIMEOUT    = SUPERALU_DEF_TIMEOUT
) (
  input logic                  CLK,
  input logic                  RST_N,
  superalu_share_sched_if.slave bus
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned TmrW = $clog2(TIMEOUT) + 1;

  sched_state_e          state_q;
  logic [NUM_REQ-1:0]    gnt_q, ack_q, win;
  logic [PtrW-1:0]       ptr_q, win_idx, gnt_idx;
  logic [TmrW-1:0]       timer_q;
  logic [DATA_WIDTH-1:0] res_a_q, res_b_q, alu_a_q, alu_b_q;
  logic [OP_WIDTH-1:0]   alu_op_q, win_op;
  logic                  err_q, alu_start_q, alu_abort_q, op_valid, still_req;

  superalu_share_sched_rr_arbiter_onehot #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req_i(bus.REQ),
    .ptr_i(ptr_q),
    .gnt_o(win)
  );

  always_comb begin
    win_idx = '0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i])   win_idx = PtrW'(i);
      if (gnt_q[i]) gnt_idx = PtrW'(i);
    end
  end

  assign win_op    = bus.REQ_OP[32'(win_idx)*OP_WIDTH +: OP_WIDTH];
  assign op_valid  = (win_op == OP_WIDTH'(SUPERALU_OP_MUL))  ||
                     (win_op == OP_WIDTH'(SUPERALU_OP_DIV))  ||
                     (win_op == OP_WIDTH'(SUPERALU_OP_SQRT)) ||
                     (win_op == OP_WIDTH'(SUPERALU_OP_CORDIC));
  // A requester that dropped REQ mid-transaction gets neither ACK nor new results.
  assign still_req = |(gnt_q & bus.REQ);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      ptr_q       <= PtrW'(NUM_REQ - 1);
      gnt_q       <= '0;
      ack_q       <= '0;
      timer_q     <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      err_q       <= 1'b0;
      alu_start_q <= 1'b0;
      alu_abort_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      ack_q       <= '0;
      alu_start_q <= 1'b0;
      alu_abort_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|bus.REQ) begin
            gnt_q    <= win;
            alu_op_q <= win_op;
            alu_a_q  <= bus.REQ_A[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            alu_b_q  <= bus.REQ_B[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            if (op_valid) begin
              state_q     <= StStart;
              alu_start_q <= 1'b1;
              timer_q     <= '0;
            end else begin
              state_q <= StResp;
              ack_q   <= win;
              err_q   <= 1'b1;
              res_a_q <= '0;
              res_b_q <= '0;
            end
          end
        end
        StStart: begin
          timer_q <= timer_q + 1'b1;
          state_q <= StWait;
        end
        StWait: begin
          timer_q <= timer_q + 1'b1;
          if (bus.ALU_DONE) begin
            state_q <= StResp;
            if (still_req) begin
              ack_q   <= gnt_q;
              err_q   <= 1'b0;
              res_a_q <= bus.ALU_FOUT;
              res_b_q <= bus.ALU_POUT;
            end
          end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
            state_q     <= StResp;
            alu_abort_q <= 1'b1;
            if (still_req) begin
              ack_q   <= gnt_q;
              err_q   <= 1'b1;
              res_a_q <= '0;
              res_b_q <= '0;
            end
          end
        end
        StResp: begin
          ptr_q   <= gnt_idx;
          gnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.ACK       = ack_q;
  assign bus.RES_A     = res_a_q;
  assign bus.RES_B     = res_b_q;
  assign bus.ERR       = err_q;
  assign bus.BUSY      = (state_q != StIdle);
  assign bus.ALU_START = alu_start_q;
  assign bus.ALU_ABORT = alu_abort_q;
  assign bus.ALU_OP    = alu_op_q;
  assign bus.ALU_A     = alu_a_q;
  assign bus.ALU_B     = alu_b_q;

endmodule

// File: tb/tb_superalu_share_sched.sv
// Directed bench for superalu_share_sched: two requesters and a hand-driven ALU.
// Cycle c is sampled on the negedge after the c-th rising edge following the request.
module tb_superalu_share_sched;
  import superalu_share_sched_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  superalu_share_sched_if #(.NUM_REQ(2), .DATA_WIDTH(16), .OP_WIDTH(3)) bus ();

  superalu_share_sched #(
    .NUM_REQ(2),
    .DATA_WIDTH(16),
    .OP_WIDTH(3),
    .TIMEOUT(64)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.REQ      = '0;
    bus.REQ_OP   = '0;
    bus.REQ_A    = '0;
    bus.REQ_B    = '0;
    bus.ALU_DONE = 1'b0;
    bus.ALU_FOUT = '0;
    bus.ALU_POUT = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.GNT !== 2'b00) $display("FAIL reset_gnt: got %b, expected 00", bus.GNT);
    if (bus.GNT !== 2'b00) n_fail++;
    n_checks++; if (bus.BUSY !== 1'b0 || bus.ALU_START !== 1'b0 || bus.ACK !== 2'b00) begin
      $display("FAIL reset_ctrl: busy=%b start=%b ack=%b, expected 0 0 00",
               bus.BUSY, bus.ALU_START, bus.ACK);
      n_fail++;
    end
    n_checks++; if (bus.RES_A !== 16'd0 || bus.ERR !== 1'b0) begin
      $display("FAIL reset_res: res_a=%0d err=%b, expected 0 0", bus.RES_A, bus.ERR);
      n_fail++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cordic();
    bus.REQ_OP[2:0] = SUPERALU_OP_CORDIC;
    bus.REQ_A[15:0] = 16'd58;
    bus.REQ_B[15:0] = 16'd50;
    bus.REQ         = 2'b01;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      bus.ALU_DONE = 1'b0;
      n_checks++; if (bus.ALU_START !== (c == 1)) begin
        $display("FAIL cordic_start c=%0d: got %b, expected %b", c, bus.ALU_START, c == 1);
        n_fail++;
      end
      n_checks++; if (bus.ACK !== ((c == 22) ? 2'b01 : 2'b00)) begin
        $display("FAIL cordic_ack c=%0d: got %b", c, bus.ACK);
        n_fail++;
      end
      if (c == 5) bus.REQ_A[15:0] = 16'd999;
      if (c == 10) begin
        n_checks++; if (bus.ALU_OP !== 3'b100 || bus.ALU_A !== 16'd58 || bus.ALU_B !== 16'd50) begin
          $display("FAIL cordic_operands: op=%0d a=%0d b=%0d, expected 4 58 50",
                   bus.ALU_OP, bus.ALU_A, bus.ALU_B);
          n_fail++;
        end
        n_checks++; if (bus.GNT !== 2'b01 || bus.BUSY !== 1'b1) begin
          $display("FAIL cordic_gnt: gnt=%b busy=%b, expected 01 1", bus.GNT, bus.BUSY);
          n_fail++;
        end
      end
      if (c == 21) begin
        bus.ALU_DONE = 1'b1;
        bus.ALU_FOUT = 16'd88;
        bus.ALU_POUT = 16'd369;
      end
      if (c == 22) begin
        n_checks++; if (bus.RES_A !== 16'd88 || bus.RES_B !== 16'd369 || bus.ERR !== 1'b0) begin
          $display("FAIL cordic_res: a=%0d b=%0d err=%b, expected 88 369 0",
                   bus.RES_A, bus.RES_B, bus.ERR);
          n_fail++;
        end
        bus.REQ = 2'b00;
      end
      if (c == 23) begin
        n_checks++; if (bus.GNT !== 2'b00 || bus.BUSY !== 1'b0) begin
          $display("FAIL cordic_idle: gnt=%b busy=%b, expected 00 0", bus.GNT, bus.BUSY);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_invalid();
    bus.REQ_OP[2:0] = 3'b111;
    bus.REQ         = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++; if (bus.ALU_START !== 1'b0) begin
        $display("FAIL invalid_start c=%0d: got %b, expected 0", c, bus.ALU_START);
        n_fail++;
      end
      if (c == 1) begin
        n_checks++; if (bus.ACK !== 2'b01 || bus.ERR !== 1'b1 || bus.RES_A !== 16'd0
                        || bus.RES_B !== 16'd0) begin
          $display("FAIL invalid_resp: ack=%b err=%b a=%0d b=%0d, expected 01 1 0 0",
                   bus.ACK, bus.ERR, bus.RES_A, bus.RES_B);
          n_fail++;
        end
        bus.REQ = 2'b00;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic pend;
    int   acks;
    pend = 1'b0;
    acks = 0;
    apply_reset();
    bus.REQ_OP = {SUPERALU_OP_MUL, SUPERALU_OP_MUL};
    bus.REQ_A  = {16'd7, 16'd3};
    bus.REQ_B  = {16'd9, 16'd5};
    bus.REQ    = 2'b11;
    for (int c = 1; c <= 40 && acks < 2; c++) begin
      @(negedge clk);
      bus.ALU_DONE = 1'b0;
      n_checks++; if ($countones(bus.GNT) > 1) begin
        $display("FAIL b2b_onehot c=%0d: gnt=%b", c, bus.GNT);
        n_fail++;
      end
      if (pend) begin
        bus.ALU_DONE = 1'b1;
        bus.ALU_FOUT = 16'(bus.ALU_A * bus.ALU_B);
        bus.ALU_POUT = 16'd0;
        pend = 1'b0;
      end
      if (bus.ALU_START) pend = 1'b1;
      if (bus.ACK !== 2'b00) begin
        acks++;
        if (acks == 1) begin
          n_checks++; if (bus.ACK !== 2'b01 || bus.RES_A !== 16'd15) begin
            $display("FAIL b2b_first: ack=%b a=%0d, expected 01 15", bus.ACK, bus.RES_A);
            n_fail++;
          end
          bus.REQ[0] = 1'b0;
        end else begin
          n_checks++; if (bus.ACK !== 2'b10 || bus.RES_A !== 16'd63 || bus.ERR !== 1'b0) begin
            $display("FAIL b2b_second: ack=%b a=%0d err=%b, expected 10 63 0",
                     bus.ACK, bus.RES_A, bus.ERR);
            n_fail++;
          end
          bus.REQ = 2'b00;
        end
      end
    end
    n_checks++; if (acks != 2) begin
      $display("FAIL b2b_count: got %0d acks, expected 2", acks);
      n_fail++;
    end
    bus.REQ = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bus.ALU_DONE    = 1'b0;
    bus.REQ_OP[5:3] = SUPERALU_OP_DIV;
    bus.REQ_A[31:16] = 16'd100;
    bus.REQ_B[31:16] = 16'd7;
    bus.REQ         = 2'b10;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++; if (bus.GNT !== 2'b10 || bus.ALU_START !== 1'b1) begin
          $display("FAIL timeout_grant: gnt=%b start=%b, expected 10 1", bus.GNT, bus.ALU_START);
          n_fail++;
        end
      end
      n_checks++; if (bus.ALU_ABORT !== (c == 65)) begin
        $display("FAIL timeout_abort c=%0d: got %b, expected %b", c, bus.ALU_ABORT, c == 65);
        n_fail++;
      end
      n_checks++; if (bus.ACK !== ((c == 65) ? 2'b10 : 2'b00)) begin
        $display("FAIL timeout_ack c=%0d: got %b", c, bus.ACK);
        n_fail++;
      end
      if (c == 65) begin
        n_checks++; if (bus.ERR !== 1'b1 || bus.RES_A !== 16'd0 || bus.RES_B !== 16'd0) begin
          $display("FAIL timeout_res: err=%b a=%0d b=%0d, expected 1 0 0",
                   bus.ERR, bus.RES_A, bus.RES_B);
          n_fail++;
        end
        bus.REQ = 2'b00;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic pend;
    logic got;
    pend = 1'b0;
    got  = 1'b0;
    bus.REQ_OP[2:0] = SUPERALU_OP_SQRT;
    bus.REQ_A[15:0] = 16'd144;
    bus.REQ_B[15:0] = 16'd0;
    bus.REQ         = 2'b01;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.GNT !== 2'b00 || bus.BUSY !== 1'b0 || bus.ACK !== 2'b00) begin
      $display("FAIL midrst_ctrl: gnt=%b busy=%b ack=%b, expected 00 0 00",
               bus.GNT, bus.BUSY, bus.ACK);
      n_fail++;
    end
    n_checks++; if (bus.ALU_OP !== 3'd0 || bus.ALU_A !== 16'd0 || bus.ERR !== 1'b0) begin
      $display("FAIL midrst_regs: op=%0d a=%0d err=%b, expected 0 0 0",
               bus.ALU_OP, bus.ALU_A, bus.ERR);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 30 && !got; c++) begin
      @(negedge clk);
      bus.ALU_DONE = 1'b0;
      if (pend) begin
        bus.ALU_DONE = 1'b1;
        bus.ALU_FOUT = 16'd12;
        bus.ALU_POUT = 16'd0;
        pend = 1'b0;
      end
      if (bus.ALU_START) pend = 1'b1;
      if (bus.ACK !== 2'b00) begin
        got = 1'b1;
        n_checks++; if (bus.ACK !== 2'b01 || bus.RES_A !== 16'd12) begin
          $display("FAIL midrst_res: ack=%b a=%0d, expected 01 12", bus.ACK, bus.RES_A);
          n_fail++;
        end
        bus.REQ = 2'b00;
      end
    end
    n_checks++; if (!got) begin
      $display("FAIL midrst_ack: got no ACK, expected one within 30 cycles");
      n_fail++;
    end
    bus.REQ = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    bus.ALU_DONE     = 1'b0;
    bus.REQ_OP       = {SUPERALU_OP_MUL, SUPERALU_OP_MUL};
    bus.REQ_A        = {16'd4, 16'd2};
    bus.REQ_B        = {16'd4, 16'd2};
    bus.REQ          = 2'b01;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      bus.ALU_DONE = 1'b0;
      if (c == 5) bus.REQ = 2'b10;
      if (c == 8) begin
        bus.ALU_DONE = 1'b1;
        bus.ALU_FOUT = 16'd777;
        bus.ALU_POUT = 16'd1;
      end
      if (c == 9) begin
        n_checks++; if (bus.ACK !== 2'b00 || bus.RES_A !== 16'd12) begin
          $display("FAIL withdraw_noack: ack=%b a=%0d, expected 00 12", bus.ACK, bus.RES_A);
          n_fail++;
        end
      end
      if (c == 10) begin
        n_checks++; if (bus.GNT !== 2'b00 || bus.BUSY !== 1'b0) begin
          $display("FAIL withdraw_idle: gnt=%b busy=%b, expected 00 0", bus.GNT, bus.BUSY);
          n_fail++;
        end
      end
      if (c == 11) begin
        n_checks++; if (bus.GNT !== 2'b10 || bus.ALU_START !== 1'b1) begin
          $display("FAIL withdraw_regrant: gnt=%b start=%b, expected 10 1",
                   bus.GNT, bus.ALU_START);
          n_fail++;
        end
      end
      if (c == 12) begin
        bus.ALU_DONE = 1'b1;
        bus.ALU_FOUT = 16'd16;
        bus.ALU_POUT = 16'd0;
      end
      if (c == 13) begin
        n_checks++; if (bus.ACK !== 2'b10 || bus.RES_A !== 16'd16) begin
          $display("FAIL withdraw_req1: ack=%b a=%0d, expected 10 16", bus.ACK, bus.RES_A);
          n_fail++;
        end
        bus.REQ = 2'b00;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_cordic();
    test_invalid();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
